// File: rtl/agc_gain_sequencer_if.sv
// agc_gain_sequencer_if: valid/ready handshake that carries the frame peak into the
// AGC gain sequencer. The peak tracker drives the master side.
interface agc_gain_sequencer_if;
   logic [15:0] peak;
   logic        peak_valid;
   logic        peak_ready;

   modport master (output peak, output peak_valid, input peak_ready);
   modport slave  (input peak, input peak_valid, output peak_ready);
endinterface

// File: rtl/agc_gain_sequencer.sv
// agc_gain_sequencer: frames input samples, divides TARGET by the frame peak serially,
// and drives the UQ5.11 gain word. Define AGC_SLEW_EN to slew-limit the gain by STEP.
module agc_gain_sequencer #(
   parameter int          FRAME_LEN = 1024,
   parameter logic [15:0] TARGET    = 16'hF0A4,
   parameter logic [15:0] GAIN_MAX  = 16'hA000,
   parameter logic [15:0] STEP      = 16'h0040
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 sample_en,
   output logic                 frame_start,
   agc_gain_sequencer_if.slave  pk,
   output logic [15:0]          gain,
   output logic                 gain_update,
   output logic                 busy
);

   localparam int            CW    = $clog2(FRAME_LEN);
   localparam logic [CW-1:0] LAST  = CW'(FRAME_LEN - 32'd1);
   localparam logic [15:0]   UNITY = 16'h0800;

   if (FRAME_LEN < 32'd2 || FRAME_LEN > 32'd65536 ||
       (FRAME_LEN & (FRAME_LEN - 32'd1)) != 32'd0 || STEP == 16'h0000) begin : g_param_check
      $error("agc_gain_sequencer: FRAME_LEN must be a power of two in 2..65536 and STEP nonzero");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DIV   = 2'd1,
      S_CLAMP = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_frame_start;
   logic [4:0]    r_bit_cnt;
   logic [15:0]   r_quot;
   logic [15:0]   r_rem;
   logic [15:0]   r_div;
   logic [15:0]   r_target;
   logic [15:0]   r_gain;
   logic          r_gain_update;
   logic          r_busy;
   logic          r_peak_ready;

   logic [16:0]   w_rem_sh;
   logic          w_ge;
   logic [15:0]   w_diff;
   logic [15:0]   w_g;
   logic [15:0]   w_clamp;
   logic          w_accept;
   logic [15:0]   w_gain_next;

   // r_quot starts as the dividend and shifts left as quotient bits enter at the bottom.
   assign w_rem_sh = {r_rem, r_quot[15]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_div});
   assign w_diff   = w_rem_sh[15:0] - r_div;
   assign w_g      = (r_quot[15:5] != 11'd0) ? 16'hFFFF : {r_quot[4:0], 11'd0};
   assign w_clamp  = (w_g > GAIN_MAX) ? GAIN_MAX : w_g;
   assign w_accept = pk.peak_valid & r_peak_ready;

   // Sample counter and frame-boundary pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt         <= {CW{1'b0}};
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         if (sample_en && enable) begin
            if (r_cnt == LAST) begin
               r_cnt         <= {CW{1'b0}};
               r_frame_start <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   // Peak handshake, restoring divider and target register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= 5'd0;
         r_quot       <= 16'h0000;
         r_rem        <= 16'h0000;
         r_div        <= 16'h0000;
         r_target     <= UNITY;
         r_busy       <= 1'b0;
         r_peak_ready <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_div        <= pk.peak;
                  r_quot       <= TARGET;
                  r_rem        <= 16'h0000;
                  r_bit_cnt    <= 5'd0;
                  r_state      <= S_DIV;
                  r_busy       <= 1'b1;
                  r_peak_ready <= 1'b0;
               end
            end
            S_DIV: begin
               // After the 16th bit one more cycle settles the divide-by-zero result.
               if (r_bit_cnt == 5'd16) begin
                  if (r_div == 16'h0000) begin
                     r_quot <= 16'hFFFF;
                  end
                  r_state <= S_CLAMP;
               end else begin
                  r_rem     <= w_ge ? w_diff : w_rem_sh[15:0];
                  r_quot    <= {r_quot[14:0], w_ge};
                  r_bit_cnt <= r_bit_cnt + 5'd1;
               end
            end
            S_CLAMP: begin
               r_target     <= w_clamp;
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
               r_peak_ready <= 1'b1;
            end
            default: begin
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
               r_peak_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef AGC_SLEW_EN
   // Step the gain toward the current target once per sample, never overshooting.
   always_comb begin
      w_gain_next = r_gain;
      if (sample_en) begin
         if (r_target > r_gain) begin
            w_gain_next = ((r_target - r_gain) > STEP) ? (r_gain + STEP) : r_target;
         end else if (r_target < r_gain) begin
            w_gain_next = ((r_gain - r_target) > STEP) ? (r_gain - STEP) : r_target;
         end else begin
            w_gain_next = r_gain;
         end
      end else begin
         w_gain_next = r_gain;
      end
   end
`else
   // Without slew limiting the gain is a copy of the target, loaded on the same edge.
   always_comb begin
      w_gain_next = r_gain;
      if (r_state == S_CLAMP) begin
         w_gain_next = w_clamp;
      end else begin
         w_gain_next = r_target;
      end
   end
`endif

   // Gain register and its change strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gain        <= UNITY;
         r_gain_update <= 1'b0;
      end else begin
         r_gain        <= w_gain_next;
         r_gain_update <= (w_gain_next != r_gain);
      end
   end

   assign frame_start   = r_frame_start;
   assign pk.peak_ready = r_peak_ready;
   assign gain          = r_gain;
   assign gain_update   = r_gain_update;
   assign busy          = r_busy;

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// tb_agc_gain_sequencer: directed scenarios with hand-computed gains for the AGC
// gain sequencer (FRAME_LEN=4, STEP=16'h0400, default TARGET/GAIN_MAX).
module tb_agc_gain_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        sample_en;
   logic        frame_start;
   logic [15:0] gain;
   logic        gain_update;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   agc_gain_sequencer_if pk_if ();

   agc_gain_sequencer #(
      .FRAME_LEN (4),
      .STEP      (16'h0400)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .sample_en   (sample_en),
      .frame_start (frame_start),
      .pk          (pk_if),
      .gain        (gain),
      .gain_update (gain_update),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b0; sample_en = 1'b0;
      pk_if.peak = 16'h0000; pk_if.peak_valid = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      n_total++; if (gain !== 16'h0800) $display("FAIL reset_gain: got %h expected 0800", gain); else n_pass++;
      n_total++; if (pk_if.peak_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", pk_if.peak_ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b expected 0", frame_start); else n_pass++;
      n_total++; if (gain_update !== 1'b0) $display("FAIL reset_gain_update: got %b expected 0", gain_update); else n_pass++;
   endtask

   task automatic test_frame_counter;
      logic exp_fs;
      enable = 1'b1; sample_en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         enable = (k >= 5 && k <= 7) ? 1'b0 : 1'b1;
         tick();
         exp_fs = (k == 4 || k == 11 || k == 15);
         n_total++;
         if (frame_start !== exp_fs)
            $display("FAIL frame_start_edge%0d: got %b expected %b", k, frame_start, exp_fs);
         else n_pass++;
      end
      enable = 1'b0; sample_en = 1'b0;
      tick();
      n_total++; if (frame_start !== 1'b0) $display("FAIL frame_start_idle: got %b expected 0", frame_start); else n_pass++;
   endtask

   task automatic run_peak(input string name, input logic [15:0] p,
                           input logic [15:0] exp_gain, input logic exp_upd);
      int busy_cnt;
      pk_if.peak = p; pk_if.peak_valid = 1'b1;
      tick();
      pk_if.peak_valid = 1'b0;
      n_total++; if (pk_if.peak_ready !== 1'b0) $display("FAIL %s_ready_low: got %b expected 0", name, pk_if.peak_ready); else n_pass++;
      busy_cnt = 0;
      for (int i = 0; i < 40 && busy === 1'b1; i++) begin
         busy_cnt++;
         tick();
      end
      n_total++; if (busy_cnt != 18) $display("FAIL %s_busy_cycles: got %0d expected 18", name, busy_cnt); else n_pass++;
      n_total++; if (gain !== exp_gain) $display("FAIL %s_gain: got %h expected %h", name, gain, exp_gain); else n_pass++;
      n_total++; if (gain_update !== exp_upd) $display("FAIL %s_gain_update: got %b expected %b", name, gain_update, exp_upd); else n_pass++;
      n_total++; if (pk_if.peak_ready !== 1'b1) $display("FAIL %s_ready_high: got %b expected 1", name, pk_if.peak_ready); else n_pass++;
      tick();
      n_total++; if (gain_update !== 1'b0) $display("FAIL %s_update_pulse: got %b expected 0", name, gain_update); else n_pass++;
   endtask

   task automatic test_nominal;
      run_peak("nominal_1E00", 16'h1E00, 16'h4000, 1'b1);
   endtask

   task automatic test_clamps;
      run_peak("peak_zero", 16'h0000, 16'hA000, 1'b1);
      run_peak("peak_0200", 16'h0200, 16'hA000, 1'b0);
      run_peak("peak_FE00", 16'hFE00, 16'h0000, 1'b1);
   endtask

   task automatic test_back_to_back;
      pk_if.peak = 16'h1E00; pk_if.peak_valid = 1'b1;
      tick();
      pk_if.peak = 16'h3C00;
      repeat (18) tick();
      n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy_e18: got %b expected 0", busy); else n_pass++;
      n_total++; if (gain !== 16'h4000) $display("FAIL b2b_first_gain: got %h expected 4000", gain); else n_pass++;
      tick();
      n_total++; if (busy !== 1'b1) $display("FAIL b2b_accept_e19_busy: got %b expected 1", busy); else n_pass++;
      n_total++; if (pk_if.peak_ready !== 1'b0) $display("FAIL b2b_accept_e19_ready: got %b expected 0", pk_if.peak_ready); else n_pass++;
      pk_if.peak_valid = 1'b0;
      repeat (18) tick();
      n_total++; if (gain !== 16'h2000) $display("FAIL b2b_final_gain: got %h expected 2000", gain); else n_pass++;
      n_total++; if (gain_update !== 1'b1) $display("FAIL b2b_final_update: got %b expected 1", gain_update); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL b2b_final_busy: got %b expected 0", busy); else n_pass++;
      tick();
   endtask

   task automatic test_slew;
      logic [15:0] exp_g;
      pk_if.peak = 16'h1E00; pk_if.peak_valid = 1'b1;
      tick();
      pk_if.peak_valid = 1'b0;
      repeat (18) tick();
      n_total++; if (busy !== 1'b0) $display("FAIL slew_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (gain !== 16'h0800) $display("FAIL slew_hold: got %h expected 0800", gain); else n_pass++;
      sample_en = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         exp_g = (k < 14) ? 16'(16'h0800 + k * 16'h0400) : 16'h4000;
         n_total++;
         if (gain !== exp_g) $display("FAIL slew_gain_step%0d: got %h expected %h", k, gain, exp_g);
         else n_pass++;
         n_total++;
         if (gain_update !== (k <= 14)) $display("FAIL slew_update_step%0d: got %b expected %b", k, gain_update, (k <= 14));
         else n_pass++;
      end
      sample_en = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_div;
      pk_if.peak = 16'hFE00; pk_if.peak_valid = 1'b1;
      tick();
      pk_if.peak_valid = 1'b0;
      repeat (5) tick();
      n_total++; if (busy !== 1'b1) $display("FAIL middiv_busy_before: got %b expected 1", busy); else n_pass++;
      n_total++; if (gain === 16'h0800) $display("FAIL middiv_gain_before: got %h expected not 0800", gain); else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_total++; if (gain !== 16'h0800) $display("FAIL middiv_async_gain: got %h expected 0800", gain); else n_pass++;
      n_total++; if (pk_if.peak_ready !== 1'b1) $display("FAIL middiv_async_ready: got %b expected 1", pk_if.peak_ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL middiv_async_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (frame_start !== 1'b0) $display("FAIL middiv_async_frame_start: got %b expected 0", frame_start); else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      repeat (20) tick();
      n_total++; if (gain !== 16'h0800) $display("FAIL middiv_discard_gain: got %h expected 0800", gain); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL middiv_discard_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (gain_update !== 1'b0) $display("FAIL middiv_discard_update: got %b expected 0", gain_update); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_frame_counter();
`ifdef AGC_SLEW_EN
      test_slew();
`else
      test_nominal();
      test_clamps();
      test_back_to_back();
`endif
      test_reset_mid_div();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached after %0d of %0d checks passed", n_pass, n_total);
      $fatal(1);
   end

endmodule
